// File: rtl/cfg_shadow_bank.sv
// +-----------------------------------------------------------------------+
// | cfg_shadow_bank: NREG x WIDTH shadow/active configuration registers    |
// | with a guarded settle-then-apply commit sequence.                      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module cfg_shadow_bank #(
  parameter int               WIDTH      = 8,
  parameter int               NREG       = 4,
  parameter int               ADDRW      = 2,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter int               SETTLE_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDRW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  commit,
  input  logic                  lock,
  output logic [NREG*WIDTH-1:0] cfg_out,
  output logic                  dirty,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_APPLY  = 2'd2
  } state_t;

  localparam logic [ADDRW:0] c_NREG   = (ADDRW+1)'(NREG);
  localparam logic [7:0]     c_SETTLE = 8'(SETTLE_CYC);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NREG*WIDTH-1:0]   shadow_q;
  logic [NREG*WIDTH-1:0]   active_q;
  logic                    dirty_q, done_q, err_q;
  logic                    w_fire, w_in_range, w_apply;

  assign wr_ready   = (state_q == S_IDLE) && !lock && !rst;
  assign w_fire     = wr_valid && wr_ready;
  assign w_in_range = ({1'b0, wr_addr} < c_NREG);
  assign w_apply    = (state_q == S_APPLY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (commit && !lock) begin
          if (SETTLE_CYC == 0) begin
            state_d = S_APPLY;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = c_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        // Leaving on the count of 1 gives exactly SETTLE_CYC cycles here.
        if (cnt_q <= 8'd1) state_d = S_APPLY;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      active_q <= {NREG{RESET_VAL}};
      dirty_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= w_apply;
      err_q   <= w_fire && !w_in_range;
      if (w_apply) begin
        active_q <= shadow_q;
        dirty_q  <= 1'b0;
      end else if (w_fire && w_in_range) begin
        dirty_q  <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_word
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q[i*WIDTH +: WIDTH] <= RESET_VAL;
      end else if (w_fire && (wr_addr == ADDRW'(i))) begin
        shadow_q[i*WIDTH +: WIDTH] <= wr_data;
      end
    end
  end

  assign cfg_out = active_q;
  assign dirty   = dirty_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cfg_shadow_bank.sv
// +-----------------------------------------------------------------------+
// | tb_cfg_shadow_bank: directed vector table, reset-mid-commit sequence   |
// | and randomized run against a behavioural model. Rev 1.0                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_cfg_shadow_bank;

  localparam int WIDTH  = 8;
  localparam int NREG   = 4;
  localparam int ADDRW  = 3;
  localparam int SETTLE = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_valid, wr_ready, commit, lock;
  logic [ADDRW-1:0]      wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [NREG*WIDTH-1:0] cfg_out;
  logic                  dirty, busy, done, err;

  int total = 0;
  int bad   = 0;

  cfg_shadow_bank #(
    .WIDTH(WIDTH), .NREG(NREG), .ADDRW(ADDRW),
    .RESET_VAL(8'h00), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .lock(lock),
    .cfg_out(cfg_out), .dirty(dirty), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  a;
    logic [7:0]  d;
    logic        c;
    logic        l;
    logic        rdy;
    logic [31:0] cfg;
    logic        dirty;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [2:0] a, input logic [7:0] d,
                     input logic c, input logic l, input logic rdy,
                     input logic [31:0] cfg, input logic dy, input logic by,
                     input logic dn, input logic er);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.c = c; r.l = l; r.rdy = rdy;
    r.cfg = cfg; r.dirty = dy; r.busy = by; r.done = dn; r.err = er;
    tbl.push_back(r);
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; lock = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: words, plus cycles remaining until the apply edge.
  logic [7:0] m_sh[NREG];
  logic [7:0] m_act[NREG];
  logic       m_dirty, m_done, m_err;
  int         m_rem;

  function automatic logic [31:0] m_cfg();
    logic [31:0] r;
    for (int i = 0; i < NREG; i++) r[i*8 +: 8] = m_act[i];
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NREG; i++) begin m_sh[i] = 8'h00; m_act[i] = 8'h00; end
    m_dirty = 0; m_done = 0; m_err = 0; m_rem = 0;
  endtask

  task automatic m_edge();
    logic rdy, fire;
    rdy  = (m_rem == 0) && !lock;
    fire = wr_valid && rdy;
    m_done = (m_rem == 1);
    m_err  = fire && (int'(wr_addr) >= NREG);
    if (m_rem == 1) begin
      for (int i = 0; i < NREG; i++) m_act[i] = m_sh[i];
      m_dirty = 0;
    end
    if (fire && int'(wr_addr) < NREG) begin
      m_sh[wr_addr] = wr_data;
      m_dirty = 1;
    end
    if (m_rem > 0)               m_rem--;
    else if (commit && !lock)    m_rem = SETTLE + 1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    do_reset();
    chk("rel_cfg",   cfg_out,           32'h00000000);
    chk("rel_ready", {31'd0, wr_ready}, 32'd1);
    chk("rel_dirty", {31'd0, dirty},    32'd0);
    chk("rel_busy",  {31'd0, busy},     32'd0);

    //   v a  d      c l rdy cfg           dy by dn er
    add(1, 1, 8'hA5, 0, 0, 1, 32'h00000000, 1, 0, 0, 0);
    add(1, 3, 8'h3C, 0, 0, 1, 32'h00000000, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1, 32'h00000000, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h00000000, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h00000000, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h00000000, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h3C00A500, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 1, 32'h3C00A500, 0, 0, 0, 0);
    // out-of-range write, then a clean commit
    add(1, 4, 8'h77, 0, 0, 1, 32'h3C00A500, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1, 32'h3C00A500, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1, 32'h3C00A500, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h3C00A500, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h3C00A500, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h3C00A500, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h3C00A500, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 1, 32'h3C00A500, 0, 0, 0, 0);
    // lock blocks write and commit
    add(1, 0, 8'hEE, 1, 1, 0, 32'h3C00A500, 0, 0, 0, 0);
    add(1, 0, 8'hEE, 1, 1, 0, 32'h3C00A500, 0, 0, 0, 0);
    // commit, then lock raised mid-SETTLE
    add(0, 0, 8'h00, 1, 0, 1, 32'h3C00A500, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 32'h3C00A500, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 32'h3C00A500, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 32'h3C00A500, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 32'h3C00A500, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 1, 32'h3C00A500, 0, 0, 0, 0);
    // write+commit same cycle, second commit during SETTLE ignored
    add(1, 0, 8'h11, 1, 0, 1, 32'h3C00A500, 1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 32'h3C00A500, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h3C00A500, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h3C00A500, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 32'h3C00A511, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 1, 32'h3C00A511, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 32'h3C00A511, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      wr_valid = tbl[i].v; wr_addr = tbl[i].a; wr_data = tbl[i].d;
      commit = tbl[i].c; lock = tbl[i].l;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, wr_ready}, {31'd0, tbl[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cfg", i),   cfg_out,          tbl[i].cfg);
      chk($sformatf("v%0d_dirty", i), {31'd0, dirty},   {31'd0, tbl[i].dirty});
      chk($sformatf("v%0d_busy", i),  {31'd0, busy},    {31'd0, tbl[i].busy});
      chk($sformatf("v%0d_done", i),  {31'd0, done},    {31'd0, tbl[i].done});
      chk($sformatf("v%0d_err", i),   {31'd0, err},     {31'd0, tbl[i].err});
    end

    // Reset asserted in SETTLE after writing addr2
    do_reset();
    wr_valid = 1; wr_addr = 3'd2; wr_data = 8'hFF;
    @(posedge clk); #1;
    chk("rs_dirty", {31'd0, dirty}, 32'd1);
    idle_inputs(); commit = 1;
    @(posedge clk); #1;
    commit = 0;
    chk("rs_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_cfg",   cfg_out,           32'h00000000);
    chk("rs_busy0", {31'd0, busy},     32'd0);
    chk("rs_dirt0", {31'd0, dirty},    32'd0);
    chk("rs_rdy0",  {31'd0, wr_ready}, 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rs_nodone", {31'd0, done}, 32'd0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rs_nodone2", {31'd0, done}, 32'd0);
    end
    commit = 1;
    @(posedge clk); #1;
    commit = 0;
    repeat (SETTLE) @(posedge clk);
    #1;
    chk("rs_pre", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("rs_cfg2", cfg_out,        32'h00000000);
    chk("rs_done", {31'd0, done},  32'd1);

    // Randomized run against the model
    do_reset();
    m_clear();
    for (int n = 0; n < 400; n++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7))
                                             : 3'($urandom_range(0, 3));
      wr_data  = 8'($urandom);
      commit   = ($urandom_range(0, 5) == 0);
      lock     = ($urandom_range(0, 6) == 0);
      #1;
      chk("r_ready", {31'd0, wr_ready}, {31'd0, (m_rem == 0) && !lock});
      m_edge();
      @(posedge clk);
      #1;
      chk("r_cfg",   cfg_out,        m_cfg());
      chk("r_dirty", {31'd0, dirty}, {31'd0, m_dirty});
      chk("r_busy",  {31'd0, busy},  {31'd0, m_rem != 0});
      chk("r_done",  {31'd0, done},  {31'd0, m_done});
      chk("r_err",   {31'd0, err},   {31'd0, m_err});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cfg_shadow_bank.md
Name: cfg_shadow_bank

Overview:
Parametrised successor to the single-register configuration block. It holds NREG configuration words of WIDTH bits in a shadow/active double-buffer. Words are written through a valid/ready port. They reach the active copy, which drives downstream consumers such as clock generators, only on a guarded commit. The block sits between the slow-control interface and the configured hard blocks; the active outputs change only on a single clean edge.

Parameters:
WIDTH, 8, bits per configuration word
NREG, 4, number of configuration words (>=1)
ADDRW, 2, address width; must satisfy 2**ADDRW >= NREG
RESET_VAL, 0, reset value of every shadow and active word (WIDTH bits)
SETTLE_CYC, 3, cycles spent in SETTLE between commit request and apply (0..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
wr_valid  input  1  write request
wr_ready  output  1  write accept
wr_addr  input  ADDRW  word index
wr_data  input  WIDTH  write data
commit  input  1  single-cycle commit request
lock  input  1  level; blocks new writes and commits
cfg_out  output  NREG*WIDTH  active words; word i at bits [i*WIDTH +: WIDTH]
dirty  output  1  shadow holds uncommitted writes
busy  output  1  commit in progress (SETTLE or APPLY)
done  output  1  one-cycle pulse when active is updated
err  output  1  one-cycle pulse on an out-of-range write

Behaviour:
- Reset (async assert, sync release): all shadow and active words = RESET_VAL, state = IDLE, cfg_out = replicated RESET_VAL. dirty=0, busy=0, done=0, err=0, wr_ready=0 during reset.
- States: IDLE, SETTLE, APPLY.
- wr_ready = (state==IDLE) && !lock && !rst. It is combinational from state, lock and rst.
- Accepted write (wr_valid && wr_ready):
  - If wr_addr < NREG: the shadow word is updated at that edge and dirty is set.
  - If wr_addr >= NREG: no write, dirty unchanged, err=1 for the next cycle.
- IDLE to SETTLE: commit && !lock while in IDLE. The settle counter loads SETTLE_CYC. If SETTLE_CYC==0, the block goes directly IDLE to APPLY.
- SETTLE: counter decrements each cycle. When it reaches 1 the state goes to APPLY next, so exactly SETTLE_CYC cycles are spent in SETTLE. wr_ready=0 and busy=1.
- APPLY (one cycle): at its closing edge, active <= shadow (all words), dirty <= 0, and done=1 for the following cycle. The state then returns to IDLE. busy=1 in APPLY.
- Commit latency: with commit sampled at edge T, cfg_out changes at edge T+SETTLE_CYC+1 and done is high in the cycle after that edge.
- Write and commit in the same IDLE cycle: the write is accepted and included in that commit.
- commit while busy: ignored, not queued.
- commit while lock=1: ignored.
- lock rising during SETTLE or APPLY: the in-progress commit completes normally.
- Commit with dirty=0: still performs SETTLE and APPLY. cfg_out is unchanged in value and done pulses.
- cfg_out is registered and changes only at the APPLY edge. Writes never alter it directly.
- rst asserted mid-commit: immediate return to reset values, so active = RESET_VAL and no done pulse.
- err and done are registered single-cycle pulses.

Test Plan:
- Reset, then release: cfg_out=32'h00000000, wr_ready=1, dirty=0, busy=0.
- Write addr1=8'hA5 and addr3=8'h3C, then check: cfg_out unchanged and dirty=1. Pulse commit: busy=1 for 4 cycles (SETTLE_CYC=3 plus APPLY), then cfg_out=32'h3C00A500, done pulse, dirty=0.
- Write with addr=4 on a bench built with NREG=4, ADDRW=3: err pulses 1 cycle, shadow and dirty unchanged, and the next commit leaves cfg_out unchanged.
- lock=1, then assert wr_valid and commit: wr_ready=0, no state change. Then commit with lock=0 during SETTLE, raising lock mid-SETTLE: apply still occurs and done pulses.
- Write addr0=8'h11 simultaneously with commit in IDLE: after 4 cycles cfg_out[7:0]=8'h11. A second commit during SETTLE is ignored and gives exactly one done pulse.
- Assert rst in the SETTLE cycle after writing addr2=8'hFF: cfg_out remains RESET_VAL, no done, and after release shadow = RESET_VAL (a commit gives all zeros).
